alarm_annunciator: RTL and testbench
====================================

# alarm_annunciator

Sequential consumer of the combinational `sAlarm` output of the vehicle alarm block. It qualifies the raw alarm level with a debounce filter and drives an intermittent buzzer pattern plus a steady warning lamp. It also supports a driver acknowledge (mute) with automatic re-arm. It sits between the `alarm` block and the cabin annunciator drivers.

## Interface
- `DEBOUNCE_CYC`, default 4: consecutive high samples of `sAlarm` required to qualify an alarm (≥1).
- `BEEP_ON`, default 8: cycles `sBuzz` is high per beep (≥1).
- `BEEP_OFF`, default 8: cycles `sBuzz` is low between beeps (≥1).
- `MAX_BEEPS`, default 4: completed beeps before the block falls silent (≥1).
- `MUTE_CYC`, default 32: mute duration in cycles (≥1).

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `sAlarm` input 1: raw alarm level from `alarm`; synchronous to `clk`, no internal synchronizer.
- `sAck` input 1: driver acknowledge level; synchronous to `clk`; only its rising edge acts.
- `sBuzz` output 1: buzzer drive, registered.
- `sLamp` output 1: warning lamp, registered; high in SOUND, HOLD, MUTED.
- `sActive` output 1: registered; high in any state other than IDLE.
- `sBeepCnt` output $clog2(MAX_BEEPS+1): completed beeps in the current sounding episode, registered.

## Operation
- States: IDLE, QUAL, SOUND, HOLD, MUTED.
- Ack edge detect: `ackRise = sAck & ~sAck_q`, where `sAck_q` is a 1-cycle registered copy.
- IDLE → QUAL when `sAlarm=1`; debounce count is loaded to 1.
- QUAL:
  - `sAlarm=0` → IDLE, count cleared.
  - Otherwise count increments.
  - On the edge where count reaches DEBOUNCE_CYC → SOUND; beep phase = ON, phase timer = 0, `sBeepCnt` = 0.
  - With DEBOUNCE_CYC=1, IDLE goes directly → SOUND.
- SOUND:
  - `sBuzz` follows the phase: ON for BEEP_ON cycles, then OFF for BEEP_OFF cycles, repeating.
  - `sBeepCnt` increments on the edge that ends each ON phase.
  - When that increment reaches MAX_BEEPS → HOLD immediately, with no trailing OFF phase.
- HOLD: `sBuzz=0`, `sLamp=1`. Exits to IDLE on `sAlarm=0`, or to MUTED on `ackRise`.
- MUTED:
  - `sBuzz=0`; the mute timer counts MUTE_CYC cycles.
  - `sAlarm=0` at any time → IDLE.
  - On timer expiry with `sAlarm=1` → SOUND; `sBeepCnt` cleared, phase = ON.
  - `ackRise` in MUTED restarts the mute timer.
- SOUND + `ackRise` → MUTED.
- Priority: `sAlarm=0` beats `ackRise` beats pattern/timer events.
- Returning to IDLE clears `sBeepCnt` and all timers.
- All counters saturate-free by construction: each is sized to $clog2(limit+1) and cleared on state entry.

## Timing
- Reset values: state IDLE, `sBuzz=0`, `sLamp=0`, `sActive=0`, `sBeepCnt=0`, `sAck_q=0`, all timers 0.
- Reset asserted mid-episode forces these values immediately, without waiting for a clock edge.
- Label edge 1 as the first rising edge sampling `sAlarm=1`. Then `sBuzz` and `sLamp` rise after edge DEBOUNCE_CYC, and `sActive` rises after edge 1.
- `sBuzz` high pulses are exactly BEEP_ON cycles; gaps are exactly BEEP_OFF cycles.
- `sAlarm` falling, sampled at edge t, drops all outputs to 0 after edge t, i.e. 1-cycle latency.
- `ackRise` sampled at edge t in SOUND: `sBuzz=0` after edge t. Re-sound occurs after edge t+MUTE_CYC if `sAlarm` is still 1.
- `sAck` held high does not re-mute; it must go low and high again.

## Structure
- Package `alarm_pkg`: `alarm_state_t` enum (IDLE, QUAL, SOUND, HOLD, MUTED) and the default parameter constants.
- Sub-module `alarm_beep_gen`:
  - Generates the ON/OFF phase and the beep-completed strobe.
  - Controls: `start` (load ON, timer 0) and `enable`.
  - Parameters: BEEP_ON, BEEP_OFF.
- The top level holds the FSM, debounce counter, mute timer, ack edge detect and output registers.

## Test plan
All scenarios use default parameters.
- **Glitch reject:** `sAlarm` high for 3 cycles, then low → `sBuzz`, `sLamp` and `sBeepCnt` stay 0; `sActive` high for 3 cycles, then 0.
- **Full pattern:** `sAlarm` held high for 100 cycles.
  - `sBuzz` rises after edge 4.
  - Four 8-cycle pulses separated by 8-cycle gaps.
  - `sBeepCnt` steps 1..4; HOLD after the 4th pulse.
  - `sLamp` stays 1; `sBuzz` stays 0 thereafter.
- **Mute and re-arm:**
  - `sAck` pulse during the 2nd ON phase → `sBuzz` 0 on the next cycle.
  - 32 cycles later `sBuzz` returns with `sBeepCnt`=0.
  - `sAck` held high throughout does not re-mute.
- **Priority:** `sAlarm` falls in the same cycle `sAck` rises, during SOUND → IDLE; all outputs 0 next cycle, no MUTED entry.
- **Async reset:** assert `rst_n`=0 between clock edges mid-beep → all outputs 0 immediately. After release with `sAlarm`=1, qualification restarts and `sBuzz` rises after 4 edges.
- **Mute ends with alarm cleared:** `sAlarm` drops during MUTED → IDLE; no buzz when the mute timer would have expired.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg
// Shared definitions for the alarm annunciator slice: the controller state
// type and the default timing constants used as parameter defaults by the
// top level and the beep generator.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUAL,
        SOUND,
        HOLD,
        MUTED
    } alarm_state_t;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_BEEP_ON      = 8;
    localparam int DEF_BEEP_OFF     = 8;
    localparam int DEF_MAX_BEEPS    = 4;
    localparam int DEF_MUTE_CYC     = 32;

endpackage

// File: rtl/alarm_beep_gen.sv
// alarm_beep_gen
// Produces the intermittent ON/OFF buzzer phase and a strobe marking the end
// of each ON phase (one completed beep).
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   start      - reload: phase ON, phase timer 0 (has priority over enable)
//   enable     - advance the phase timer this cycle
//   nextOn     - phase value that will be current after this edge
//   beepDone   - high on the edge that ends an ON phase
module alarm_beep_gen
    import alarm_pkg::*;
#(
    parameter int BEEP_ON  = DEF_BEEP_ON,
    parameter int BEEP_OFF = DEF_BEEP_OFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic enable,
    output logic nextOn,
    output logic beepDone
);

    localparam int TIMER_W = $clog2(((BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF) + 1);
    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(BEEP_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(BEEP_OFF - 1);

    logic               phaseOn;
    logic [TIMER_W-1:0] timer;
    logic               phaseEnd;

    // The current phase ends when its timer has counted the last cycle of
    // that phase. The look-ahead phase lets the owner register the buzzer
    // output in the same edge as the phase change, so there is no extra lag.
    always_comb begin
        phaseEnd = phaseOn ? (timer == ON_LAST) : (timer == OFF_LAST);
        beepDone = enable & ~start & phaseOn & phaseEnd;
        nextOn   = phaseOn;
        if (start) begin
            nextOn = 1'b1;
        end else if (enable && phaseEnd) begin
            nextOn = ~phaseOn;
        end
    end

    // Phase and timer registers. Holding start high keeps the generator
    // parked at the beginning of an ON phase, ready for the next episode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phaseOn <= 1'b1;
            timer   <= '0;
        end else if (start) begin
            phaseOn <= 1'b1;
            timer   <= '0;
        end else if (enable) begin
            if (phaseEnd) begin
                phaseOn <= ~phaseOn;
                timer   <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_annunciator.sv
// alarm_annunciator
// Qualifies the raw alarm level with a debounce filter, then drives an
// intermittent buzzer pattern and a steady warning lamp, with a driver
// acknowledge that mutes the buzzer for a while before re-arming.
// Ports:
//   clk, rst_n - clock and asynchronous active-low reset
//   sAlarm     - raw alarm level (already synchronous to clk)
//   sAck       - driver acknowledge level; only its rising edge acts
//   sBuzz      - registered buzzer drive
//   sLamp      - registered warning lamp (SOUND, HOLD, MUTED)
//   sActive    - registered, high whenever the controller is not idle
//   sBeepCnt   - registered count of completed beeps in this episode
module alarm_annunciator
    import alarm_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int BEEP_ON      = DEF_BEEP_ON,
    parameter int BEEP_OFF     = DEF_BEEP_OFF,
    parameter int MAX_BEEPS    = DEF_MAX_BEEPS,
    parameter int MUTE_CYC     = DEF_MUTE_CYC
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             sAlarm,
    input  logic                             sAck,
    output logic                             sBuzz,
    output logic                             sLamp,
    output logic                             sActive,
    output logic [$clog2(MAX_BEEPS+1)-1:0]   sBeepCnt
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int MUTE_W = $clog2(MUTE_CYC + 1);
    localparam int CNT_W  = $clog2(MAX_BEEPS + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC);
    localparam logic [MUTE_W-1:0] MUTE_LAST = MUTE_W'(MUTE_CYC);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(MAX_BEEPS);

    alarm_state_t      state;
    logic [DEB_W-1:0]  debCnt;
    logic [MUTE_W-1:0] muteTimer;
    logic              sAckQ;

    logic              ackRise;
    logic              beepStart;
    logic              beepEnable;
    logic              beepNextOn;
    logic              beepDone;
    logic [DEB_W-1:0]  debNext;
    logic [MUTE_W-1:0] muteNext;
    logic [CNT_W-1:0]  cntNext;

    // Acknowledge acts on its rising edge only, so a held button cannot
    // re-mute. The beep generator stays parked at "ON, timer 0" whenever we
    // are not sounding, so every entry into SOUND starts a fresh ON phase.
    always_comb begin
        ackRise    = sAck & ~sAckQ;
        beepStart  = (state != SOUND);
        beepEnable = (state == SOUND);
        debNext    = debCnt + 1'b1;
        muteNext   = muteTimer + 1'b1;
        cntNext    = sBeepCnt + 1'b1;
    end

    alarm_beep_gen #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF)
    ) u_beepGen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (beepStart),
        .enable   (beepEnable),
        .nextOn   (beepNextOn),
        .beepDone (beepDone)
    );

    // Controller FSM with registered outputs. A low alarm level wins over
    // everything and returns to IDLE with all counters cleared; next comes
    // the acknowledge edge, then the pattern and timer events. IDLE and QUAL
    // share the debounce branch because debCnt is always 0 in IDLE, which
    // also makes a one-cycle debounce go straight from IDLE to SOUND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            debCnt    <= '0;
            muteTimer <= '0;
            sAckQ     <= 1'b0;
            sBeepCnt  <= '0;
            sBuzz     <= 1'b0;
            sLamp     <= 1'b0;
            sActive   <= 1'b0;
        end else begin
            sAckQ <= sAck;
            if (!sAlarm) begin
                state     <= IDLE;
                debCnt    <= '0;
                muteTimer <= '0;
                sBeepCnt  <= '0;
                sBuzz     <= 1'b0;
                sLamp     <= 1'b0;
                sActive   <= 1'b0;
            end else begin
                case (state)
                    IDLE, QUAL: begin
                        sActive <= 1'b1;
                        if (debNext == DEB_LAST) begin
                            state    <= SOUND;
                            debCnt   <= '0;
                            sBeepCnt <= '0;
                            sBuzz    <= 1'b1;
                            sLamp    <= 1'b1;
                        end else begin
                            state  <= QUAL;
                            debCnt <= debNext;
                        end
                    end
                    SOUND: begin
                        if (ackRise) begin
                            state     <= MUTED;
                            muteTimer <= '0;
                            sBuzz     <= 1'b0;
                        end else if (beepDone && (cntNext == CNT_LAST)) begin
                            state    <= HOLD;
                            sBeepCnt <= cntNext;
                            sBuzz    <= 1'b0;
                        end else begin
                            if (beepDone) begin
                                sBeepCnt <= cntNext;
                            end
                            sBuzz <= beepNextOn;
                        end
                    end
                    HOLD: begin
                        if (ackRise) begin
                            state     <= MUTED;
                            muteTimer <= '0;
                        end
                    end
                    MUTED: begin
                        if (ackRise) begin
                            muteTimer <= '0;
                        end else if (muteNext == MUTE_LAST) begin
                            state     <= SOUND;
                            muteTimer <= '0;
                            sBeepCnt  <= '0;
                            sBuzz     <= 1'b1;
                        end else begin
                            muteTimer <= muteNext;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        sBuzz   <= 1'b0;
                        sLamp   <= 1'b0;
                        sActive <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alarm_annunciator.sv
// tb_alarm_annunciator
// Drives directed scenarios plus randomized alarm/acknowledge traffic into
// alarm_annunciator (default parameters) and compares every output after
// every edge against a behavioural model built from the episode rules:
// run length of high samples, age of the sounding episode, age of the mute.
module tb_alarm_annunciator;

    localparam int DEB    = 4;
    localparam int ON     = 8;
    localparam int OFF    = 8;
    localparam int PERIOD = ON + OFF;
    localparam int MAXB   = 4;
    localparam int MUTE   = 32;

    localparam int M_IDLE  = 0;
    localparam int M_QUAL  = 1;
    localparam int M_SOUND = 2;
    localparam int M_HOLD  = 3;
    localparam int M_MUTED = 4;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic       sAlarm = 1'b0;
    logic       sAck   = 1'b0;
    logic       sBuzz;
    logic       sLamp;
    logic       sActive;
    logic [2:0] sBeepCnt;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    int mMode;
    int highRun;
    int soundAge;
    int muteAge;
    int beeps;
    bit prevAck;
    bit ackLvl;

    alarm_annunciator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sAlarm   (sAlarm),
        .sAck     (sAck),
        .sBuzz    (sBuzz),
        .sLamp    (sLamp),
        .sActive  (sActive),
        .sBeepCnt (sBeepCnt)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, observed, expected);
        end
    endtask

    // Model back to its power-on condition.
    task automatic modelReset();
        mMode    = M_IDLE;
        highRun  = 0;
        soundAge = 0;
        muteAge  = 0;
        beeps    = 0;
        prevAck  = 1'b0;
    endtask

    // Completed beeps after a given number of edges spent sounding.
    function automatic int beepsAtAge(input int age);
        return (age >= ON) ? ((age - ON) / PERIOD + 1) : 0;
    endfunction

    // Advance the model by one clock edge using the sampled input levels.
    task automatic modelStep(input bit a, input bit k);
        bit rise;
        rise    = k && !prevAck;
        prevAck = k;
        if (!a) begin
            mMode    = M_IDLE;
            highRun  = 0;
            soundAge = 0;
            muteAge  = 0;
            beeps    = 0;
        end else begin
            case (mMode)
                M_IDLE, M_QUAL: begin
                    highRun++;
                    if (highRun >= DEB) begin
                        mMode    = M_SOUND;
                        soundAge = 0;
                        beeps    = 0;
                        highRun  = 0;
                    end else begin
                        mMode = M_QUAL;
                    end
                end
                M_SOUND: begin
                    if (rise) begin
                        mMode   = M_MUTED;
                        muteAge = 0;
                    end else begin
                        soundAge++;
                        beeps = beepsAtAge(soundAge);
                        if (beeps >= MAXB) mMode = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (rise) begin
                        mMode   = M_MUTED;
                        muteAge = 0;
                    end
                end
                default: begin
                    if (rise) begin
                        muteAge = 0;
                    end else begin
                        muteAge++;
                        if (muteAge >= MUTE) begin
                            mMode    = M_SOUND;
                            soundAge = 0;
                            beeps    = 0;
                            muteAge  = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    task automatic checkAll();
        int expBuzz;
        expBuzz = (mMode == M_SOUND && (soundAge % PERIOD) < ON) ? 1 : 0;
        checkOutput("sBuzz", int'(sBuzz), expBuzz);
        checkOutput("sLamp", int'(sLamp),
                    (mMode == M_SOUND || mMode == M_HOLD || mMode == M_MUTED) ? 1 : 0);
        checkOutput("sActive", int'(sActive), (mMode != M_IDLE) ? 1 : 0);
        checkOutput("sBeepCnt", int'(sBeepCnt),
                    (mMode == M_IDLE || mMode == M_QUAL) ? 0 : beeps);
    endtask

    // Hold the given input levels for n edges, checking after each edge.
    task automatic applyStimulus(input bit a, input bit k, input int n);
        for (int i = 0; i < n; i++) begin
            sAlarm = a;
            sAck   = k;
            @(posedge clk);
            modelStep(a, k);
            #1;
            cycle++;
            checkAll();
        end
    endtask

    // Pulse reset between edges and confirm outputs drop without a clock.
    task automatic asyncReset();
        sAck   = 1'b0;
        ackLvl = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        modelReset();
        checkAll();
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        ackLvl = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        rst_n = 1'b1;

        $display("[TB] glitch reject");
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 5);

        $display("[TB] full pattern");
        applyStimulus(1'b1, 1'b0, 100);
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] mute and re-arm, ack held high");
        applyStimulus(1'b1, 1'b0, 22);
        applyStimulus(1'b1, 1'b1, 50);
        applyStimulus(1'b1, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 5);
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] alarm drop beats ack");
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b0, 3);

        $display("[TB] alarm clears during mute");
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 40);

        $display("[TB] asynchronous reset mid-beep");
        applyStimulus(1'b1, 1'b0, 6);
        asyncReset();
        applyStimulus(1'b1, 1'b0, 10);
        applyStimulus(1'b0, 1'b0, 2);

        $display("[TB] randomized episodes");
        for (int ep = 0; ep < 30; ep++) begin
            int len;
            int gap;
            len = $urandom_range(1, 110);
            gap = $urandom_range(1, 4);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 15) == 0) ackLvl = ~ackLvl;
                applyStimulus(1'b1, ackLvl, 1);
            end
            if (ep % 10 == 5) asyncReset();
            for (int c = 0; c < gap; c++) begin
                if ($urandom_range(0, 7) == 0) ackLvl = ~ackLvl;
                applyStimulus(1'b0, ackLvl, 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
